// File: rtl/divider_if.sv
// Handshake/result bundle for the signed 32-bit iterative divider.
// Optional dbz flag appears only when DIVIDER_DBZ_EN is defined.
interface divider_if;
    logic [31:0] x;
    logic [31:0] y;
    logic        start;
    logic [63:0] z;
    logic        busy;
`ifdef DIVIDER_DBZ_EN
    logic        dbz;

    modport master (output x, y, start, input z, busy, dbz);
    modport slave  (input x, y, start, output z, busy, dbz);
`else
    modport master (output x, y, start, input z, busy);
    modport slave  (input x, y, start, output z, busy);
`endif
endinterface

// File: rtl/divider.sv
// Signed 32-bit restoring divider, one quotient bit per cycle.
// z = {remainder, quotient}; busy high for 33 cycles per operation.
// Optional feature macro: DIVIDER_DBZ_EN (adds dbz flag and forced DBZ result).
module divider (
    input  logic      clk,
    input  logic      rst_n,
    divider_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state, state_nxt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] div;
    logic [5:0]  cnt;
    logic        sign_q;
    logic        sign_r;
    logic [63:0] z_r;
    logic        busy_r;
`ifdef DIVIDER_DBZ_EN
    logic        y_zero;
    logic        dbz_r;
`endif

    logic [31:0] x_abs, y_abs;
    logic [32:0] shifted, trial;
    logic [31:0] q_fix, r_fix;

    // Operand magnitudes, trial subtract and sign restoration
    always_comb begin
        x_abs   = bus.x[31] ? -bus.x : bus.x;
        y_abs   = bus.y[31] ? -bus.y : bus.y;
        // rem < div <= 2^31 so the shifted value fits 32 bits; bit 32 of trial is the borrow
        shifted = {rem[31:0], quo[31]};
        trial   = shifted - {1'b0, div};
        q_fix   = sign_q ? -quo : quo;
        r_fix   = sign_r ? -rem[31:0] : rem[31:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (cnt == 6'd1) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, shift-subtract iteration, result write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            quo    <= '0;
            div    <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            z_r    <= '0;
            busy_r <= 1'b0;
`ifdef DIVIDER_DBZ_EN
            y_zero <= 1'b0;
            dbz_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    sign_q <= bus.x[31] ^ bus.y[31];
                    sign_r <= bus.x[31];
                    quo    <= x_abs;
                    div    <= y_abs;
                    rem    <= '0;
                    cnt    <= 6'd32;
                    busy_r <= 1'b1;
`ifdef DIVIDER_DBZ_EN
                    y_zero <= (bus.y == 32'd0);
`endif
                end
                CALC: begin
                    rem <= trial[32] ? shifted : trial;
                    quo <= {quo[30:0], ~trial[32]};
                    cnt <= cnt - 6'd1;
                end
                FIX: begin
                    busy_r <= 1'b0;
`ifdef DIVIDER_DBZ_EN
                    // r_fix recovers the original dividend since rem ends as |x| when div=0
                    z_r   <= y_zero ? {r_fix, 32'hFFFF_FFFF} : {r_fix, q_fix};
                    dbz_r <= y_zero;
`else
                    z_r   <= {r_fix, q_fix};
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.z    = z_r;
    assign bus.busy = busy_r;
`ifdef DIVIDER_DBZ_EN
    assign bus.dbz  = dbz_r;
`endif
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed plan cases plus random operands
// compared against an arithmetic reference model.
module tb_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;
    int   cyc = 0;

    divider_if bus ();

    divider u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: signed 64-bit arithmetic, truncating division
    function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b);
        int          sa, sb;
        longint      la, lb, lq, lr;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        la = sa;
        lb = sb;
        if (b == 32'd0) begin
`ifdef DIVIDER_DBZ_EN
            q = 32'hFFFF_FFFF;
`else
            q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
`endif
            r = a;
        end else begin
            lq = la / lb;
            lr = la % lb;
            q  = 32'(lq);
            r  = 32'(lr);
        end
        return {r, q};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 64'(bus.busy), 64'd0);
    endtask

    // Launch one op, measure busy length, check result against model
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        wait_idle();
        bus.x = a;
        bus.y = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.x = $urandom;
        bus.y = $urandom;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy"}, 64'(n), 64'd33);
        chk({tag, "_z"}, bus.z, ref_div(a, b));
`ifdef DIVIDER_DBZ_EN
        chk({tag, "_dbz"}, 64'(bus.dbz), 64'(b == 32'd0));
`endif
    endtask

    initial begin
        int r1, r2, n;
        logic prev;
        logic [31:0] ra, rb;
        bus.x = '0;
        bus.y = '0;
        bus.start = 1'b0;

        // reset state
        #12;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_z", bus.z, 64'd0);
`ifdef DIVIDER_DBZ_EN
        chk("rst_dbz", 64'(bus.dbz), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed plan cases
        run_op("pos", 32'd100, 32'd7);
        chk("pos_const", bus.z, 64'h00000002_0000000E);
        run_op("negx", -32'sd100, 32'd7);
        run_op("negy", 32'd100, -32'sd7);
        run_op("negxy", -32'sd100, -32'sd7);
        run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
        chk("ovf_const", bus.z, 64'h00000000_80000000);
        run_op("min_by1", 32'h8000_0000, 32'd1);
        run_op("zero_x", 32'd0, -32'sd5);
        run_op("dbz_pos", 32'd5, 32'd0);
        chk("dbz_pos_const", bus.z, 64'h00000005_FFFFFFFF);
        run_op("dbz_neg", -32'sd5, 32'd0);

        // start while busy is ignored
        wait_idle();
        bus.x = 32'd100; bus.y = 32'd7; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.x = 32'd9; bus.y = 32'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        chk("ignore_z", bus.z, 64'h00000002_0000000E);
        repeat (3) @(negedge clk);
        chk("ignore_idle", 64'(bus.busy), 64'd0);

        // start held high: accepts 34 cycles apart
        bus.x = 32'd100; bus.y = 32'd7; bus.start = 1'b1;
        r1 = -1; r2 = -1; n = 0;
        prev = bus.busy;
        while (r2 < 0 && n < 200) begin
            @(negedge clk);
            n++;
            if (!prev && bus.busy) begin
                if (r1 < 0) r1 = cyc;
                else        r2 = cyc;
            end
            prev = bus.busy;
        end
        chk("held_period", 64'(r2 - r1), 64'd34);
        bus.start = 1'b0;
        wait_idle();

        // reset mid-operation
        run_op("pre_rst", 32'd100, 32'd7);
        bus.x = 32'd100; bus.y = 32'd7; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_z", bus.z, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_hold", bus.z, 64'd0);
        run_op("post_rst", 32'd9, 32'd3);
        chk("post_rst_const", bus.z, 64'h00000000_00000003);

        // random operands, with some small / zero divisors mixed in
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case (i % 4)
                0:       rb = $urandom;
                1:       rb = 32'($urandom_range(0, 20)) - 32'd10;
                2:       rb = {{16{ra[31]}}, 16'($urandom)};
                default: rb = 32'($urandom_range(1, 1000));
            endcase
            if (i == 5) rb = 32'd0;
            run_op("rand", ra, rb);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/divider.md
# divider

Signed 32-bit iterative divider: the inverse companion of the team's sequential Booth multiplier, sharing its start/busy handshake and 64-bit packed result. Computes quotient and remainder of two's-complement operands with a restoring shift-subtract core, one quotient bit per cycle. Sits beside the multiplier in the execute-stage arithmetic unit and feeds the HI/LO-style result registers.

## Interface
- No parameters; operand width fixed at 32 bits.
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- x  input  32  dividend, signed two's complement
- y  input  32  divisor, signed two's complement
- start  input  1  request; sampled only when busy=0
- z  output  64  result: z[63:32] remainder, z[31:0] quotient
- busy  output  1  1 while dividing; falls on the same edge that z is written
- dbz  output  1  divide-by-zero flag (present only with DIVIDER_DBZ_EN)

## Operation
- States: IDLE, CALC, FIX.
- IDLE: on an edge with start=1, latch sign_q = x[31]^y[31] and sign_r = x[31]. Latch |x| into the quotient/shift register and |y| into the divisor register, clear the 33-bit partial remainder, set cnt=32, set busy=1, and go to CALC. |−2^31| is 0x80000000, treated as unsigned.
- CALC, each cycle:
  - Shift {rem, quo} left 1.
  - Trial subtract: t = rem − {1'b0, div} (33-bit).
  - If t ≥ 0: rem=t and the new quo LSB is 1. Otherwise keep rem and the new LSB is 0.
  - Decrement cnt; on cnt reaching 0, go to FIX.
- FIX:
  - q = sign_q ? −quo : quo; r = sign_r ? −rem[31:0] : rem[31:0].
  - z <= {r, q}; busy <= 0; go to IDLE.
- Arithmetic rules:
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign, or is 0.
  - x = r + q·y holds whenever y ≠ 0 and not overflow.
- Overflow: x=0x80000000, y=0xFFFFFFFF gives q=0x80000000, r=0. No flag.
- Divide by zero, base build: the algorithm runs unmodified. Unsigned quotient is 0xFFFFFFFF and unsigned remainder is |x|. After sign fix, q = x[31] ? 0x00000001 : 0xFFFFFFFF, and r = x.
- z holds its value between operations; it changes only in FIX or on reset.
- start while busy=1: ignored, with no restart and no queueing. x and y may change freely after the start edge.

## Timing
- Reset (rst_n low, asynchronous): busy=0, z=0, dbz=0, state IDLE, all internal registers 0. Effective immediately, mid-operation included. The in-flight operation is abandoned and z is not updated.
- First clock edge with rst_n high and start=1 begins an operation.
- Let E0 be the edge sampling start=1 in IDLE:
  - busy is 1 after E0.
  - E1..E32: CALC iterations.
  - E33: FIX writes z and clears busy.
  - busy is high for exactly 33 cycles; result is valid at busy's falling edge.
- Back-to-back: start=1 on E33 is not accepted, because busy=1 when sampled. The earliest next accept is E34 (start high in the first cycle busy=0), giving a 34-cycle throughput.
- start level, not edge: start held high in IDLE launches a new operation every 34 cycles.

## Configuration
- DIVIDER_DBZ_EN defined:
  - Adds the dbz output.
  - At E0, y==0 is latched. FIX asserts dbz=1 and forces z = {x, 0xFFFFFFFF} regardless of sign.
  - Otherwise dbz=0 is written in FIX.
  - dbz holds with z until the next FIX or reset. Latency is unchanged.
- DIVIDER_DBZ_EN undefined: no dbz port; divide-by-zero follows the base-build rule in Operation.

## Test plan
- Positive operands: x=100, y=7 -> busy high exactly 33 cycles, then z=0x00000002_0000000E.
- Mixed signs: x=−100, y=7 -> z=0xFFFFFFFE_FFFFFFF2. x=100, y=−7 -> z=0x00000002_FFFFFFF2. x=−100, y=−7 -> z=0xFFFFFFFE_0000000E.
- Extremes: x=0x80000000, y=0xFFFFFFFF -> z=0x00000000_80000000. x=0x80000000, y=1 -> z=0x00000000_80000000. x=0, y=−5 -> z=0.
- Divide by zero: x=5, y=0 -> base build gives z=0x00000005_FFFFFFFF; with DIVIDER_DBZ_EN, same z and dbz=1. x=−5, y=0 -> base build gives z=0xFFFFFFFB_00000001; with the macro, z=0xFFFFFFFB_FFFFFFFF and dbz=1.
- Handshake: start 100/7, then pulse start with x=9, y=3 at cycle 10 -> ignored, z=0x00000002_0000000E. Start held high -> second accept exactly 34 cycles after the first.
- Reset mid-operation: start 100/7, drop rst_n at cycle 15 -> busy=0 and z=0 immediately. Release and start 9/3 -> z=0x00000000_00000003 after 33 cycles.
